bram_dp_param: RTL and testbench
================================

Name: bram_dp_param

Overview:
- Parametrised successor to the team's single-port 32-bit BRAM: simple dual-port block RAM with a read/write port A and a read-only port B.
- Adds byte-enable writes, selectable read latency, selectable port-A write mode and a built-in sequential clear engine.
- Sits between the RLS datapath and coefficient/sample storage; port B feeds the MAC pipeline while port A is used for load/update.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 15, address width; DEPTH = 2**ADDR_W words.
- READ_LATENCY, 1, read latency in cycles; legal values are 1 and 2.
- WRITE_MODE, 0, port A same-cycle read on write: 0 = read-first, 1 = write-first.
- CLEAR_VAL, 0, DATA_W-bit word written by the clear engine.

Ports:
- clka  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  port A access enable.
- wea  in  DATA_W/8  port A byte write enables; bit i covers dina[8i+7:8i].
- addra  in  ADDR_W  port A address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A read data.
- douta_vld  out  1  high for one cycle when douta carries a new read result.
- enb  in  1  port B read enable.
- addrb  in  ADDR_W  port B address.
- doutb  out  DATA_W  port B read data.
- doutb_vld  out  1  high for one cycle when doutb carries a new read result.
- clr_start  in  1  one-cycle request to clear the whole array.
- clr_busy  out  1  high while the clear is in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset values: douta=0, doutb=0, douta_vld=0, doutb_vld=0, clr_busy=0, clr_done=0. The FSM enters IDLE and the clear counter goes to 0, including all pipeline stages.
- Memory contents are not affected by reset.
- Port A, ena=1:
  - Every byte with wea[i]=1 is written at the edge.
  - A read of addra is always performed.
  - WRITE_MODE=0: the returned word is the pre-write contents.
  - WRITE_MODE=1: the returned word is the merged post-write word.
- Port B, enb=1: reads addrb.
- Latency: the result appears on douta/doutb, with the matching vld high, exactly READ_LATENCY edges after the sampling edge.
  - LATENCY 2 adds one output register stage.
- When not enabled, dout holds its last value and vld=0. Back-to-back reads give one result per cycle.
- Collision: if port A writes address X and port B reads X in the same cycle, port B returns the old data. The next read of X returns the new data.
- Clear FSM:
  - IDLE, clr_start=1 -> CLEAR. Counter starts at 0; clr_busy=1 from the next cycle.
  - CLEAR writes CLEAR_VAL to address counter each cycle and increments the counter. After address DEPTH-1 is written -> DONE, so clr_busy is high for DEPTH cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
- During CLEAR/DONE:
  - Port A is ignored: no write, no read, douta_vld stays 0.
  - clr_start is ignored.
  - Port B reads proceed. Addresses not yet cleared return old data; the address being cleared that cycle also returns old data, per the collision rule.
- clr_start together with an ena write in IDLE: the port A write is performed and the clear starts on the next cycle, overwriting it.
- Reset during CLEAR aborts immediately:
  - Addresses below the counter value are cleared; the rest keep old contents.
  - No clr_done pulse is produced.
  - In-flight reads are dropped and their vld is never asserted.

Test Plan:
- Use ADDR_W=4, DATA_W=32 and READ_LATENCY=1 unless a scenario states otherwise.
- Write/read: write i to addresses 0..9 (wea=4'hF), then read 0..9 on A and B -> douta=doutb=i with vld one cycle after each read; repeat with READ_LATENCY=2 -> two cycles.
- Byte enable: write 0xAABBCCDD to address 5, then wea=4'b0010 with dina=0x11223344 -> reading address 5 returns 0xAABB33DD.
- Write mode: address 3 holds 0x1, then a port A write of 0x2 to address 3 -> douta=0x1 with WRITE_MODE=0 and 0x2 with WRITE_MODE=1.
- Collision: A writes 0x55 to address 7 while B reads address 7 (old value 0x7) -> doutb=0x7; the next B read gives 0x55.
- Clear: fill all 16 words, set CLEAR_VAL=0xDEADBEEF, pulse clr_start.
  - clr_busy is high for 16 cycles, then clr_done pulses once.
  - A port A write of 0x99 to address 2 during busy is ignored.
  - All 16 reads afterwards return 0xDEADBEEF.
- Reset mid-clear: after 7 clear writes, assert rst -> clr_busy=0 immediately and no clr_done. Addresses 0..6 read CLEAR_VAL; addresses 7..15 read their prior data.

Source files
------------

// File: rtl/bram_dp_param.sv
// rtl/bram_dp_param.sv - simple dual-port block RAM with byte enables and a sequential clear engine
//
// Ports:
//   clka                 rising-edge clock for all logic
//   rst                  asynchronous active-high reset (memory contents preserved)
//   ena/wea/addra/dina   port A access enable, byte write enables, address, write data
//   douta/douta_vld      port A read data and one-cycle new-result strobe
//   enb/addrb            port B read enable and address
//   doutb/doutb_vld      port B read data and one-cycle new-result strobe
//   clr_start            one-cycle request to fill the whole array with CLEAR_VAL
//   clr_busy/clr_done    clear in progress / one-cycle completion pulse
module bram_dp_param #(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 15,
   parameter int                READ_LATENCY = 1,
   parameter int                WRITE_MODE   = 0,
   parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
   input  logic                  clka,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [DATA_W/8-1:0]   wea,
   input  logic [ADDR_W-1:0]     addra,
   input  logic [DATA_W-1:0]     dina,
   output logic [DATA_W-1:0]     douta,
   output logic                  douta_vld,
   input  logic                  enb,
   input  logic [ADDR_W-1:0]     addrb,
   output logic [DATA_W-1:0]     doutb,
   output logic                  doutb_vld,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t               state;
   logic [ADDR_W-1:0]    clr_cnt;
   logic [DATA_W-1:0]    mem [DEPTH];

   logic                 a_act;
   logic [NB-1:0]        wr_be;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic [DATA_W-1:0]    a_old;
   logic [DATA_W-1:0]    a_merged;
   logic [DATA_W-1:0]    a_rd;

   logic [DATA_W-1:0]    a_q1;
   logic                 a_v1;
   logic [DATA_W-1:0]    b_q1;
   logic                 b_v1;

   // Port A is locked out for the whole clear, including the DONE cycle.
   assign a_act = ena && (state == IDLE) && !rst;

   // Single physical write port shared by the clear engine and port A.
   always_comb begin
      wr_be   = '0;
      wr_addr = addra;
      wr_data = dina;
      if (state == CLEAR) begin
         wr_be   = '1;
         wr_addr = clr_cnt;
         wr_data = CLEAR_VAL;
      end else if (a_act) begin
         wr_be = wea;
      end
   end

   always_ff @(posedge clka) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Write-first returns the word as it will look after this edge's byte merge.
   always_comb begin
      a_old = mem[addra];
      for (int i = 0; i < NB; i++) begin
         a_merged[8*i +: 8] = wea[i] ? dina[8*i +: 8] : a_old[8*i +: 8];
      end
      a_rd = (WRITE_MODE == 1) ? a_merged : a_old;
   end

   // Clear FSM: busy covers exactly DEPTH write cycles, done follows for one cycle.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clr_done <= 1'b0;
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_cnt  <= '0;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == {ADDR_W{1'b1}}) begin
                  state    <= DONE;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   // First read stage; port B samples the array before this edge's write lands,
   // which gives the old-data collision behaviour.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         a_q1 <= '0;
         a_v1 <= 1'b0;
         b_q1 <= '0;
         b_v1 <= 1'b0;
      end else begin
         a_v1 <= a_act;
         if (a_act) begin
            a_q1 <= a_rd;
         end
         b_v1 <= enb;
         if (enb) begin
            b_q1 <= mem[addrb];
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_W-1:0] a_q2;
         logic              a_v2;
         logic [DATA_W-1:0] b_q2;
         logic              b_v2;

         always_ff @(posedge clka or posedge rst) begin
            if (rst) begin
               a_q2 <= '0;
               a_v2 <= 1'b0;
               b_q2 <= '0;
               b_v2 <= 1'b0;
            end else begin
               a_v2 <= a_v1;
               if (a_v1) begin
                  a_q2 <= a_q1;
               end
               b_v2 <= b_v1;
               if (b_v1) begin
                  b_q2 <= b_q1;
               end
            end
         end

         assign douta     = a_q2;
         assign douta_vld = a_v2;
         assign doutb     = b_q2;
         assign doutb_vld = b_v2;
      end else begin : g_lat1
         assign douta     = a_q1;
         assign douta_vld = a_v1;
         assign doutb     = b_q1;
         assign doutb_vld = b_v1;
      end
   endgenerate

endmodule

// File: tb/tb_bram_dp_param.sv
// tb/tb_bram_dp_param.sv - scoreboard bench for bram_dp_param, two configurations driven in parallel
module tb_bram_dp_param;

   localparam int          N  = 16;
   localparam logic [31:0] CV = 32'hDEADBEEF;

   logic        clka = 1'b0;
   logic        rst  = 1'b1;
   logic        ena  = 1'b0;
   logic [3:0]  wea  = 4'h0;
   logic [3:0]  addra = 4'h0;
   logic [31:0] dina = 32'h0;
   logic        enb  = 1'b0;
   logic [3:0]  addrb = 4'h0;
   logic        clr_start = 1'b0;

   logic [31:0] douta0, doutb0, douta1, doutb1;
   logic        douta_vld0, doutb_vld0, douta_vld1, doutb_vld1;
   logic        clr_busy0, clr_done0, clr_busy1, clr_done1;

   // dut0: latency 1, read-first.  dut1: latency 2, write-first.
   bram_dp_param #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_VAL(CV)) dut0 (
      .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta0), .douta_vld(douta_vld0), .enb(enb), .addrb(addrb),
      .doutb(doutb0), .doutb_vld(doutb_vld0), .clr_start(clr_start),
      .clr_busy(clr_busy0), .clr_done(clr_done0));

   bram_dp_param #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_VAL(CV)) dut1 (
      .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta1), .douta_vld(douta_vld1), .enb(enb), .addrb(addrb),
      .doutb(doutb1), .doutb_vld(doutb_vld1), .clr_start(clr_start),
      .clr_busy(clr_busy1), .clr_done(clr_done1));

   always #5 clka = ~clka;

   int cyc = 0;
   always @(posedge clka) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      bit          k;
      int          c;
   } exp_t;

   exp_t qa0[$];
   exp_t qa1[$];
   exp_t qb0[$];
   exp_t qb1[$];

   logic [31:0] mem [N];
   bit          kn  [N];
   int          clr_pos = -1;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_d [4];
   bit          last_k [4];
   string       pn [4] = '{"a0", "a1", "b0", "b1"};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic flush_model();
      qa0.delete();
      qa1.delete();
      qb0.delete();
      qb1.delete();
      clr_pos = -1;
      for (int p = 0; p < 4; p++) begin
         last_d[p] = 32'h0;
         last_k[p] = 1'b1;
      end
   endtask

   // One clock edge: applies the spec rules to the inputs sampled there.
   task automatic tick();
      logic [31:0] ob, old, mg;
      bit          obk, oldk, mgk, busy_e, done_e;
      int          s;
      @(posedge clka);
      #1;
      s   = cyc;
      ob  = mem[addrb];
      obk = kn[addrb];
      if (clr_pos < 0) begin
         if (ena) begin
            old  = mem[addra];
            oldk = kn[addra];
            for (int i = 0; i < 4; i++) mg[8*i +: 8] = wea[i] ? dina[8*i +: 8] : old[8*i +: 8];
            mgk = oldk || (wea == 4'hF);
            qa0.push_back('{old, oldk, s});
            qa1.push_back('{mg, mgk, s + 1});
            mem[addra] = mg;
            kn[addra]  = mgk;
         end
         if (clr_start) clr_pos = 0;
      end else if (clr_pos < N) begin
         mem[clr_pos] = CV;
         kn[clr_pos]  = 1'b1;
         clr_pos++;
      end else begin
         clr_pos = -1;
      end
      if (enb) begin
         qb0.push_back('{ob, obk, s});
         qb1.push_back('{ob, obk, s + 1});
      end
      busy_e = (clr_pos >= 0) && (clr_pos < N);
      done_e = (clr_pos == N);
      chk("clr_busy0", {31'b0, clr_busy0}, {31'b0, busy_e});
      chk("clr_busy1", {31'b0, clr_busy1}, {31'b0, busy_e});
      chk("clr_done0", {31'b0, clr_done0}, {31'b0, done_e});
      chk("clr_done1", {31'b0, clr_done1}, {31'b0, done_e});
   endtask

   task automatic drive(input bit ea, input logic [3:0] we, input int aa, input logic [31:0] da,
                        input bit eb, input int ab, input bit cs);
      ena       = ea;
      wea       = we;
      addra     = 4'(aa);
      dina      = da;
      enb       = eb;
      addrb     = 4'(ab);
      clr_start = cs;
      tick();
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_douta0"}, douta0, 32'h0);
      chk({tag, "_doutb0"}, doutb0, 32'h0);
      chk({tag, "_douta1"}, douta1, 32'h0);
      chk({tag, "_doutb1"}, doutb1, 32'h0);
      chk({tag, "_vld0"}, {30'b0, douta_vld0, doutb_vld0}, 32'h0);
      chk({tag, "_vld1"}, {30'b0, douta_vld1, doutb_vld1}, 32'h0);
      chk({tag, "_busy"}, {30'b0, clr_busy0, clr_busy1}, 32'h0);
      chk({tag, "_done"}, {30'b0, clr_done0, clr_done1}, 32'h0);
   endtask

   task automatic q_front(input int p, output bit have, output exp_t e);
      have = 1'b0;
      e    = '{32'h0, 1'b0, 0};
      case (p)
         0: if (qa0.size() > 0) begin e = qa0[0]; have = 1'b1; end
         1: if (qa1.size() > 0) begin e = qa1[0]; have = 1'b1; end
         2: if (qb0.size() > 0) begin e = qb0[0]; have = 1'b1; end
         default: if (qb1.size() > 0) begin e = qb1[0]; have = 1'b1; end
      endcase
   endtask

   task automatic q_pop(input int p);
      case (p)
         0: qa0.delete(0);
         1: qa1.delete(0);
         2: qb0.delete(0);
         default: qb1.delete(0);
      endcase
   endtask

   task automatic mon(input int p, input logic v, input logic [31:0] d);
      exp_t e;
      bit   have;
      q_front(p, have, e);
      if (v) begin
         if (!have) begin
            chk({pn[p], "_unexpected_vld"}, 32'h1, 32'h0);
         end else begin
            q_pop(p);
            if (e.k) chk({pn[p], "_data"}, d, e.d);
            chk({pn[p], "_latency"}, cyc, e.c);
            last_d[p] = e.d;
            last_k[p] = e.k;
         end
      end else begin
         if (have && e.c <= cyc) begin
            chk({pn[p], "_missing_vld"}, 32'h0, 32'h1);
            q_pop(p);
         end
         if (last_k[p]) chk({pn[p], "_hold"}, d, last_d[p]);
      end
   endtask

   always @(negedge clka) begin
      if (!rst) begin
         mon(0, douta_vld0, douta0);
         mon(1, douta_vld1, douta1);
         mon(2, doutb_vld0, doutb0);
         mon(3, doutb_vld1, doutb1);
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         mem[i] = 32'h0;
         kn[i]  = 1'b0;
      end
      flush_model();

      // Reset state.
      repeat (3) @(posedge clka);
      #1;
      check_reset_outputs("reset");
      #1;
      rst = 1'b0;

      // Write i to 0..9, then read back on both ports.
      for (int i = 0; i < 10; i++) drive(1'b1, 4'hF, i, 32'(i), 1'b0, 0, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 4'h0, i, 32'h0, 1'b1, i, 1'b0);
      idle();
      for (int i = 10; i < N; i++) drive(1'b1, 4'hF, i, $urandom, 1'b0, 0, 1'b0);

      // Byte enables.
      drive(1'b1, 4'hF, 5, 32'hAABBCCDD, 1'b0, 0, 1'b0);
      drive(1'b1, 4'b0010, 5, 32'h11223344, 1'b0, 0, 1'b0);
      drive(1'b1, 4'h0, 5, 32'h0, 1'b1, 5, 1'b0);
      idle();
      idle();

      // Write mode: read-first vs write-first on the same write.
      drive(1'b1, 4'hF, 3, 32'h1, 1'b0, 0, 1'b0);
      drive(1'b1, 4'hF, 3, 32'h2, 1'b0, 0, 1'b0);
      idle();

      // Collision: B sees the old word, then the new one.
      drive(1'b1, 4'hF, 7, 32'h55, 1'b1, 7, 1'b0);
      drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 7, 1'b0);
      repeat (3) idle();

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         drive(1'($urandom), 4'($urandom), int'($urandom_range(0, N - 1)), $urandom,
               1'($urandom), int'($urandom_range(0, N - 1)), 1'b0);
      end
      repeat (2) idle();

      // Full clear, started together with a port A write to address 2.
      drive(1'b1, 4'hF, 2, 32'h12345678, 1'b0, 0, 1'b1);
      drive(1'b1, 4'hF, 2, 32'h99, 1'b1, 2, 1'b0);
      for (int n = 0; n < N; n++) begin
         drive(1'($urandom), 4'($urandom), int'($urandom_range(0, N - 1)), $urandom,
               1'($urandom), int'($urandom_range(0, N - 1)), 1'($urandom));
      end
      idle();
      for (int i = 0; i < N; i++) drive(1'b1, 4'h0, i, 32'h0, 1'b1, i, 1'b0);
      repeat (2) idle();

      // Reset in the middle of a clear.
      for (int i = 0; i < N; i++) drive(1'b1, 4'hF, i, $urandom, 1'b0, 0, 1'b0);
      drive(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, 1'b1);
      for (int n = 0; n < 7; n++) drive(1'b0, 4'h0, 0, 32'h0, 1'b1, n + 6, 1'b0);
      ena = 1'b0; wea = 4'h0; enb = 1'b0; clr_start = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midclr_rst");
      flush_model();
      #1;
      rst = 1'b0;
      repeat (N + 2) idle();
      for (int i = 0; i < N; i++) drive(1'b1, 4'h0, i, 32'h0, 1'b1, N - 1 - i, 1'b0);
      repeat (4) idle();

      chk("queues_drained", 32'(qa0.size() + qa1.size() + qb0.size() + qb1.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
